// File: rtl/gb_write_capture.sv
// Captures completed GameBoy cartridge-bus write cycles, filters them by
// address, timestamps them with the GameBoy tick counter and queues them in a
// FIFO for a valid/ready readout consumer.
module gb_write_capture #(
    parameter int unsigned COUNTER_WIDTH = 25,
    parameter int unsigned TS_WIDTH      = 16,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned MIN_LOW       = 3,
    parameter logic [15:0] MATCH_ADDR    = 16'h0000,
    parameter logic [15:0] MATCH_MASK    = 16'h0000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic [14:0]              adr_in,
    input  logic                     ncs,
    input  logic [7:0]               data_in,
    input  logic                     nwr,
    input  logic [COUNTER_WIDTH-1:0] tick_count,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [24+TS_WIDTH-1:0]   rec_data,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic [7:0]               glitch_count
);

    localparam int unsigned RecWidth = 24 + TS_WIDTH;
    localparam int unsigned AddrW    = $clog2(DEPTH);
    localparam int unsigned LowW     = $clog2(MIN_LOW + 1);
    localparam logic [LowW-1:0] MinLow = LowW'(MIN_LOW);

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StCommit
    } state_e;

    state_e                state_q, state_d;
    logic [LowW-1:0]       lowcnt_q, lowcnt_d;
    logic [15:0]           addr_q, addr_d;
    logic [7:0]            data_q, data_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [7:0]            glitch_count_q, drop_count_q;
    logic                  overflow_q;
    logic                  glitch_inc;
    logic                  push;

    logic [RecWidth-1:0]   mem_q [DEPTH];
    logic [AddrW:0]        wptr_q, rptr_q;
    logic                  empty, full, pop, push_ok, drop;

    logic [15:0]           cur_addr;
    logic                  addr_match;
    logic                  unused_tick;

    // A15 comes in on the n_cs pin, so it is simply the top address bit.
    assign cur_addr   = {ncs, adr_in};
    assign addr_match = ((addr_q ^ MATCH_ADDR) & MATCH_MASK) == 16'h0000;
    // Only the low TS_WIDTH bits are recorded; the rest wrap away by design.
    assign unused_tick = ^tick_count;

    // Capture FSM next-state: qualify nwr low pulses and snapshot the cycle.
    always_comb begin
        state_d    = state_q;
        lowcnt_d   = lowcnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        ts_d       = ts_q;
        glitch_inc = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!nwr && arm) begin
                    state_d  = StLow;
                    lowcnt_d = LowW'(1);
                    addr_d   = cur_addr;
                    data_d   = data_in;
                    ts_d     = tick_count[TS_WIDTH-1:0];
                end
            end
            StLow: begin
                if (!nwr) begin
                    if (lowcnt_q < MinLow) begin
                        lowcnt_d = lowcnt_q + 1'b1;
                    end
                    // Last low sample wins for address/data; timestamp stays.
                    addr_d = cur_addr;
                    data_d = data_in;
                end else if (lowcnt_q >= MinLow) begin
                    state_d = StCommit;
                end else begin
                    glitch_inc = 1'b1;
                    state_d    = StIdle;
                end
            end
            StCommit: begin
                push = addr_match;
                if (!nwr && arm) begin
                    state_d  = StLow;
                    lowcnt_d = LowW'(1);
                    addr_d   = cur_addr;
                    data_d   = data_in;
                    ts_d     = tick_count[TS_WIDTH-1:0];
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Capture FSM state and snapshot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            lowcnt_q <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            ts_q     <= '0;
        end else begin
            state_q  <= state_d;
            lowcnt_q <= lowcnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ts_q     <= ts_d;
        end
    end

    // FIFO status; a pop in the same cycle frees the slot for a push when full.
    assign empty   = wptr_q == rptr_q;
    assign full    = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                     (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
    assign pop     = !empty && rec_ready;
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q[AddrW-1:0]] <= {addr_q, data_q, ts_q};
        end
    end

    // FIFO pointers and sticky/saturating status counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            overflow_q     <= 1'b0;
            drop_count_q   <= '0;
            glitch_count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_q <= drop_count_q + 8'd1;
                end
            end
            if (glitch_inc && glitch_count_q != 8'hFF) begin
                glitch_count_q <= glitch_count_q + 8'd1;
            end
        end
    end

    assign rec_valid    = !empty;
    assign rec_data     = mem_q[rptr_q[AddrW-1:0]];
    assign overflow     = overflow_q;
    assign drop_count   = drop_count_q;
    assign glitch_count = glitch_count_q;

endmodule

// File: tb/tb_gb_write_capture.sv
// Directed self-checking bench for gb_write_capture. One instance accepts all
// addresses, a second one only matches 0x01FF.
module tb_gb_write_capture;

    logic        clk;
    logic        reset;
    logic        arm;
    logic [14:0] adr_in;
    logic        ncs;
    logic [7:0]  data_in;
    logic        nwr;
    logic [24:0] tick_count;
    logic        rec_ready;

    logic        rec_valid;
    logic [39:0] rec_data;
    logic        overflow;
    logic [7:0]  drop_count;
    logic [7:0]  glitch_count;

    logic        m_rec_valid;
    logic [39:0] m_rec_data;
    logic        m_overflow;
    logic [7:0]  m_drop_count;
    logic [7:0]  m_glitch_count;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];

    gb_write_capture dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .adr_in       (adr_in),
        .ncs          (ncs),
        .data_in      (data_in),
        .nwr          (nwr),
        .tick_count   (tick_count),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_data     (rec_data),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .glitch_count (glitch_count)
    );

    gb_write_capture #(
        .MATCH_ADDR (16'h01FF),
        .MATCH_MASK (16'hFFFF)
    ) dut_m (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .adr_in       (adr_in),
        .ncs          (ncs),
        .data_in      (data_in),
        .nwr          (nwr),
        .tick_count   (tick_count),
        .rec_valid    (m_rec_valid),
        .rec_ready    (rec_ready),
        .rec_data     (m_rec_data),
        .overflow     (m_overflow),
        .drop_count   (m_drop_count),
        .glitch_count (m_glitch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [39:0] rec(input logic [15:0] a, input logic [7:0] d,
                                        input logic [24:0] t);
        return {a, d, t[15:0]};
    endfunction

    task automatic set_bus(input logic [15:0] a, input logic [7:0] d);
        ncs     = a[15];
        adr_in  = a[14:0];
        data_in = d;
    endtask

    // Called just after a posedge; returns just after a posedge with any
    // committed record already visible.
    task automatic do_write(input logic [15:0] a, input logic [7:0] d,
                            input logic [24:0] t, input int nlow);
        set_bus(a, d);
        tick_count = t;
        nwr = 1'b0;
        repeat (nlow) @(posedge clk);
        #1;
        nwr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_one();
        rec_ready = 1'b1;
        @(posedge clk);
        #1;
        rec_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; arm = 1'b1; nwr = 1'b1; rec_ready = 1'b0;
        set_bus(16'h0000, 8'h00);
        tick_count = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b expected 0", rec_valid);
        end
        checks++;
        if (overflow !== 1'b0 || drop_count !== 8'd0 || glitch_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_status: got ovf=%b drop=%0d glitch=%0d expected 0/0/0",
                     overflow, drop_count, glitch_count);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        set_bus(16'h01FF, 8'h55);
        tick_count = 25'h123456;
        nwr = 1'b0;
        @(posedge clk);
        #1;
        // Timestamp must keep the first-low value; data takes the last sample.
        tick_count = 25'h1ABCDE;
        data_in = 8'h31;
        repeat (3) @(posedge clk);
        #1;
        nwr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL single_commit_valid: got %b expected 0", rec_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rec_valid !== 1'b1) begin
            errors++; $display("FAIL single_valid: got %b expected 1", rec_valid);
        end
        checks++;
        if (rec_data !== rec(16'h01FF, 8'h31, 25'h123456)) begin
            errors++;
            $display("FAIL single_data: got %h expected %h", rec_data,
                     rec(16'h01FF, 8'h31, 25'h123456));
        end
        @(posedge clk);
        #1;
        pop_one();
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL single_one_record: got valid %b expected 0", rec_valid);
        end
    endtask

    task automatic test_glitch();
        do_write(16'h0200, 8'hAA, 25'h0000111, 2);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (glitch_count !== 8'd1) begin
            errors++; $display("FAIL glitch_count: got %0d expected 1", glitch_count);
        end
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL glitch_no_record: got valid %b expected 0", rec_valid);
        end
        // Exactly MIN_LOW low samples must qualify, proving the FSM is idle again.
        do_write(16'h0201, 8'hBB, 25'h0000777, 3);
        checks++;
        if (rec_valid !== 1'b1 || rec_data !== rec(16'h0201, 8'hBB, 25'h0000777)) begin
            errors++;
            $display("FAIL glitch_recover: got valid=%b data=%h expected 1/%h",
                     rec_valid, rec_data, rec(16'h0201, 8'hBB, 25'h0000777));
        end
        checks++;
        if (glitch_count !== 8'd1) begin
            errors++; $display("FAIL glitch_stable: got %0d expected 1", glitch_count);
        end
        pop_one();
    endtask

    task automatic test_arm();
        arm = 1'b0;
        do_write(16'h0300, 8'hCC, 25'h0000222, 4);
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL arm_off: got valid %b expected 0", rec_valid);
        end
        // Disarming mid-cycle must not abort the write in progress.
        arm = 1'b1;
        set_bus(16'h0301, 8'hDD);
        tick_count = 25'h0000555;
        nwr = 1'b0;
        @(posedge clk);
        #1;
        arm = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nwr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rec_valid !== 1'b1 || rec_data !== rec(16'h0301, 8'hDD, 25'h0000555)) begin
            errors++;
            $display("FAIL arm_fall_completes: got valid=%b data=%h expected 1/%h",
                     rec_valid, rec_data, rec(16'h0301, 8'hDD, 25'h0000555));
        end
        arm = 1'b1;
        pop_one();
    endtask

    task automatic test_match();
        apply_reset();
        do_write(16'h01FF, 8'h11, 25'h0000100, 4);
        do_write(16'h8000, 8'h22, 25'h0000200, 4);
        do_write(16'h01FF, 8'h33, 25'h0000300, 4);
        checks++;
        if (m_rec_valid !== 1'b1 || m_rec_data !== rec(16'h01FF, 8'h11, 25'h0000100)) begin
            errors++;
            $display("FAIL match_first: got valid=%b data=%h expected 1/%h",
                     m_rec_valid, m_rec_data, rec(16'h01FF, 8'h11, 25'h0000100));
        end
        pop_one();
        checks++;
        if (m_rec_valid !== 1'b1 || m_rec_data !== rec(16'h01FF, 8'h33, 25'h0000300)) begin
            errors++;
            $display("FAIL match_second: got valid=%b data=%h expected 1/%h",
                     m_rec_valid, m_rec_data, rec(16'h01FF, 8'h33, 25'h0000300));
        end
        checks++;
        if (rec_data !== rec(16'h8000, 8'h22, 25'h0000200)) begin
            errors++;
            $display("FAIL match_all_a15: got %h expected %h", rec_data,
                     rec(16'h8000, 8'h22, 25'h0000200));
        end
        pop_one();
        checks++;
        if (m_rec_valid !== 1'b0) begin
            errors++; $display("FAIL match_count: got valid %b expected 0", m_rec_valid);
        end
        checks++;
        if (m_overflow !== 1'b0 || m_drop_count !== 8'd0 || m_glitch_count !== 8'd0) begin
            errors++;
            $display("FAIL match_status: got ovf=%b drop=%0d glitch=%0d expected 0/0/0",
                     m_overflow, m_drop_count, m_glitch_count);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        exp_q.delete();
        rec_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            do_write(16'h0100 + 16'(i), 8'(i), 25'(i * 65536 + 4096 + i), 4);
            if (i < 16) exp_q.push_back(rec(16'h0100 + 16'(i), 8'(i), 25'(4096 + i)));
            if (i == 15) begin
                checks++;
                if (overflow !== 1'b0) begin
                    errors++; $display("FAIL ovf_at_full: got %b expected 0", overflow);
                end
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_flag: got %b expected 1", overflow);
        end
        checks++;
        if (drop_count !== 8'd2) begin
            errors++; $display("FAIL ovf_drop_count: got %0d expected 2", drop_count);
        end
        rec_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (rec_valid !== 1'b1 || rec_data !== exp_q[k]) begin
                errors++;
                $display("FAIL ovf_drain[%0d]: got valid=%b data=%h expected 1/%h",
                         k, rec_valid, rec_data, exp_q[k]);
            end
            @(posedge clk);
            #1;
        end
        rec_ready = 1'b0;
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL ovf_drain_empty: got valid %b expected 0", rec_valid);
        end
    endtask

    task automatic test_full_pop_push();
        apply_reset();
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            do_write(16'h0400 + 16'(i), 8'h40 + 8'(i), 25'h0002000 + 25'(i), 4);
            exp_q.push_back(rec(16'h0400 + 16'(i), 8'h40 + 8'(i), 25'h0002000 + 25'(i)));
        end
        set_bus(16'h04AA, 8'hEE);
        tick_count = 25'h0002AAA;
        nwr = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        nwr = 1'b1;
        @(posedge clk);
        #1;
        // Now in the commit cycle: pop and push land on the same edge.
        rec_ready = 1'b1;
        @(posedge clk);
        #1;
        rec_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(rec(16'h04AA, 8'hEE, 25'h0002AAA));
        checks++;
        if (overflow !== 1'b0 || drop_count !== 8'd0) begin
            errors++;
            $display("FAIL fullpop_nodrop: got ovf=%b drop=%0d expected 0/0",
                     overflow, drop_count);
        end
        rec_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (rec_valid !== 1'b1 || rec_data !== exp_q[k]) begin
                errors++;
                $display("FAIL fullpop_drain[%0d]: got valid=%b data=%h expected 1/%h",
                         k, rec_valid, rec_data, exp_q[k]);
            end
            @(posedge clk);
            #1;
        end
        rec_ready = 1'b0;
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL fullpop_empty: got valid %b expected 0", rec_valid);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_write(16'h0500, 8'h55, 25'h0003000, 4);
        do_write(16'h0501, 8'h66, 25'h0003001, 1);
        checks++;
        if (rec_valid !== 1'b1 || glitch_count !== 8'd1) begin
            errors++;
            $display("FAIL rmid_setup: got valid=%b glitch=%0d expected 1/1",
                     rec_valid, glitch_count);
        end
        set_bus(16'h0502, 8'h77);
        tick_count = 25'h0003333;
        nwr = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_async_valid: got %b expected 0", rec_valid);
        end
        checks++;
        if (glitch_count !== 8'd0 || drop_count !== 8'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL rmid_async_status: got glitch=%0d drop=%0d ovf=%b expected 0/0/0",
                     glitch_count, drop_count, overflow);
        end
        tick_count = 25'h0003444;
        #2;
        reset = 1'b0;
        // Three low edges after release qualify only if capture starts on the first.
        repeat (3) @(posedge clk);
        #1;
        nwr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rec_valid !== 1'b0) begin
            errors++; $display("FAIL rmid_commit_valid: got %b expected 0", rec_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rec_valid !== 1'b1 || rec_data !== rec(16'h0502, 8'h77, 25'h0003444)) begin
            errors++;
            $display("FAIL rmid_new_capture: got valid=%b data=%h expected 1/%h",
                     rec_valid, rec_data, rec(16'h0502, 8'h77, 25'h0003444));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_glitch();
        test_arm();
        test_match();
        test_overflow();
        test_full_pop_push();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gb_write_capture.md
Name: gb_write_capture

Overview:
- Sits downstream of the SB_IO-registered GameBoy bus inputs (adr_in, data_in, nrd, nwr, ncs) and the clock-tick counter of the clock/ROM-emulation top.
- Detects completed CPU write cycles on the cartridge bus and filters them by address.
- Timestamps each qualified write with the GameBoy clock-tick count and queues it in a FIFO for a readout consumer (UART dumper or LED stepper), using a valid/ready handshake.
- Replaces the single "latch write to 0x1ff into LEDs" register with a lossless log of many writes.

Parameters:
- COUNTER_WIDTH, 25, width of the tick_count input.
- TS_WIDTH, 16, number of low tick_count bits stored per record; must be ≤ COUNTER_WIDTH.
- DEPTH, 16, FIFO entries; must be a power of two and ≥ 2.
- MIN_LOW, 3, consecutive clk samples with nwr low needed to qualify a write; must be ≥ 1.
- MATCH_ADDR, 16'h0000, address compare value.
- MATCH_MASK, 16'h0000, address bits that must match; 0 means accept all.

Ports:
- clk  in  1  fabric clock (PLL output), all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- arm  in  1  capture enable; when low, no new records are started.
- adr_in  in  15  registered A0-A14.
- ncs  in  1  registered A15 (n_cs pin level).
- data_in  in  8  registered D0-D7.
- nwr  in  1  registered #wr.
- tick_count  in  COUNTER_WIDTH  GameBoy clock-tick counter.
- rec_valid  out  1  FIFO head record available.
- rec_ready  in  1  consumer accepts head record.
- rec_data  out  24+TS_WIDTH  record {addr[15:0], data[7:0], ts[TS_WIDTH-1:0]}, MSB first.
- overflow  out  1  sticky flag: at least one record was dropped.
- drop_count  out  8  saturating count of dropped records.
- glitch_count  out  8  saturating count of nwr low pulses shorter than MIN_LOW.

Behaviour:
- Reset, asynchronous: rec_valid=0, overflow=0, drop_count=0, glitch_count=0, FSM=IDLE, FIFO empty, pointers=0. rec_data is don't-care while rec_valid=0.
- Composed address = {ncs, adr_in}. ncs is A15 itself, so ncs=0 means A15=0.
- Address match condition: ((addr ^ MATCH_ADDR) & MATCH_MASK) == 0.

FSM:
- IDLE: when nwr=0 and arm=1, go to LOW with lowcnt=1. Snapshot addr, data_in and tick_count[TS_WIDTH-1:0].
- LOW, nwr=0: lowcnt increments, saturating at MIN_LOW. addr and data are re-snapshotted every cycle, so the last low sample wins. The timestamp keeps its first-low value.
- LOW, nwr=1 and lowcnt ≥ MIN_LOW: go to COMMIT.
- LOW, nwr=1 and lowcnt < MIN_LOW: increment glitch_count, go to IDLE, produce no record.
- COMMIT, one cycle:
  - If the address matches, push the record.
  - If the address does not match, drop silently; this does not count as a drop.
  - Go to IDLE, or directly to LOW if nwr=0 and arm=1 in this cycle.
- If arm falls during LOW, the cycle in progress still completes.

FIFO:
- Push in COMMIT cycle N makes rec_valid=1 in cycle N+1 when the FIFO was empty.
- A pop happens when rec_valid && rec_ready at a posedge. rec_data always shows the head entry.
- Full and push with no pop: record dropped, overflow←1, drop_count+1 saturating at 255.
- Full and push with pop in the same cycle: the pop frees a slot and the push is accepted, with no drop.
- Empty and push: pop is not possible that cycle because rec_valid=0.
- Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full when the MSBs differ and the low bits are equal.
- tick_count is truncated, not saturated; the ts field wraps modulo 2^TS_WIDTH.
- The glitch and drop counters hold at 255 and clear only on reset.

Test Plan:
1. Reset, then nwr low 4 clk, adr_in=0x1ff, ncs=0, data_in=0x31, tick_count=0x123456, arm=1, mask=0, rec_ready=0 → exactly one record; rec_valid rises 1 cycle after COMMIT; rec_data={0x01FF,0x31,0x3456}.
2. nwr low for 2 clk with MIN_LOW=3 → no record; glitch_count=1; FSM back in IDLE.
3. MATCH_ADDR=0x01FF, MATCH_MASK=0xFFFF; write to 0x01FF, 0x8000 (ncs=1), 0x01FF → FIFO holds exactly 2 records; overflow=0.
4. rec_ready=0; 18 qualified writes with DEPTH=16 → 16 stored; overflow=1; drop_count=2. Then drain with rec_ready=1 → records come out in order; rec_valid falls after the 16th.
5. FIFO full, push in the same cycle as rec_ready=1 pop → no drop; occupancy stays 16; the new record is last out.
6. Assert reset while in LOW and with a non-empty FIFO → rec_valid=0 immediately (asynchronous) and all counters 0. After release, nwr still low and arm=1 → a new capture starts on the next clk.
